rowptr_len_gen: RTL and testbench
=================================

// Module: rowptr_len_gen
// PURPOSE
//  Upstream feeder of the SpMV row-clear controller: converts a CSR row_ptr stream
//  into per-row nonzero counts (row_ptr[i+1]-row_ptr[i]), one AXIS beat per row.
//  Its m_len_* output drives the controller's S_AXIS_TIMES port, which then asserts
//  clr at each row boundary. Also tags rows with an index and flags malformed input.
// PARAMETERS
//  PTR_W  32  width of row_ptr entries and of emitted row lengths
//  ROW_W  32  width of the per-matrix row index counter
// PORTS
//  clk           in   1      clock
//  rstn          in   1      reset, asynchronous assert, active-low
//  s_ptr_tvalid  in   1      row_ptr beat valid
//  s_ptr_tdata   in   PTR_W  row_ptr value
//  s_ptr_tlast   in   1      marks final row_ptr (row_ptr[N]) of a matrix
//  s_ptr_tready  out  1      row_ptr beat accepted when valid&ready
//  m_len_tvalid  out  1      row length valid
//  m_len_tdata   out  PTR_W  nonzero count of current row
//  m_len_tlast   out  1      length belongs to last row of matrix
//  m_len_tready  in   1      downstream ready
//  m_row_idx     out  ROW_W  row index of m_len_tdata, qualified by m_len_tvalid
//  done          out  1      1-cycle pulse when last pointer of a matrix is accepted
//  err_nonmono   out  1      sticky: a row_ptr smaller than its predecessor was seen
// BEHAVIOUR
//  Reset (rstn=0, async): state=S_FIRST, m_len_tvalid=0, m_len_tdata=0,
//   m_len_tlast=0, m_row_idx=0, prev=0, row counter=0, done=0, err_nonmono=0.
//   Reset mid-matrix discards held output and partial matrix; no beat is replayed.
//  FSM, 2 states:
//   S_FIRST: s_ptr_tready=1. Accepted beat -> prev<=tdata, row counter<=0, no output.
//     If that beat has tlast (zero-row matrix): done pulses, stay S_FIRST; else ->S_RUN.
//   S_RUN: s_ptr_tready = ~m_len_tvalid | m_len_tready (single output register).
//     Accepted beat p -> output reg loads len=p-prev (PTR_W bits, modulo), tlast=s_ptr_tlast,
//     m_row_idx=row counter; prev<=p; row counter+=1 (wraps mod 2^ROW_W).
//     If s_ptr_tlast: done pulses same cycle as acceptance edge, ->S_FIRST.
//  Output reg: tvalid set on load, cleared on m_len_tvalid&m_len_tready with no new load;
//   simultaneous drain+load keeps tvalid=1 with new data. Data stable while valid&~ready.
//  Latency: 1 cycle accepted pointer -> m_len_tvalid. Throughput 1 row/cycle when
//   m_len_tready=1; first pointer of each matrix costs 1 input beat, no output bubble
//   beyond that.
//  Empty rows (p==prev) are emitted with length 0; never skipped.
//  Non-monotonic (p<prev, unsigned): emit length 0, set err_nonmono (held until reset),
//   prev<=p, processing continues.
//  Back-to-back matrices: next matrix's row_ptr[0] may be accepted the cycle after the
//   previous tlast beat, even while the last length is still held in the output reg.
//  s_ptr_tready has no combinational path from s_ptr_tvalid; it depends only on
//   state, m_len_tvalid and m_len_tready.
// TESTING
//  T1 ptrs {0,3,3,7} tlast on 7, tready=1 -> lens 3,0,4 idx 0,1,2, tlast on 4; done once.
//  T2 same stream, m_len_tready low 3 cycles while len=3 held -> data/idx stable,
//     s_ptr_tready=0 in S_RUN, no loss/duplication; resume yields 0,4.
//  T3 single ptr {5} with tlast -> no m_len beat, done pulses, next matrix {0,2} -> len 2 idx 0.
//  T4 ptrs {8,4,6} -> lens 0,2; err_nonmono=1 after 4 accepted, stays 1 until rstn=0.
//  T5 two matrices {0,1,4}+{0,2} streamed continuously, tready=1 -> 1,3(tlast),2(tlast);
//     idx 0,1,0; two done pulses.
//  T6 rstn asserted while len held and mid-matrix -> m_len_tvalid=0 immediately; after
//     release {10,12} gives len 2 idx 0, err_nonmono=0.

Source files
------------

// File: rtl/rowptr_len_gen.sv
// Converts a CSR row_ptr stream into per-row nonzero counts, one AXIS beat per row,
// tagged with the row index; flags pointers that go backwards.
module rowptr_len_gen #(
  parameter int unsigned PTR_W = 32,
  parameter int unsigned ROW_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_ptr_tvalid,
  input  logic [PTR_W-1:0] s_ptr_tdata,
  input  logic             s_ptr_tlast,
  output logic             s_ptr_tready,
  output logic             m_len_tvalid,
  output logic [PTR_W-1:0] m_len_tdata,
  output logic             m_len_tlast,
  input  logic             m_len_tready,
  output logic [ROW_W-1:0] m_row_idx,
  output logic             done,
  output logic             err_nonmono
);

  typedef enum logic [0:0] {StFirst, StRun} state_e;

  state_e           state_q, state_d;
  logic             tvalid_q, tvalid_d;
  logic [PTR_W-1:0] tdata_q, tdata_d;
  logic             tlast_q, tlast_d;
  logic [ROW_W-1:0] idx_q, idx_d;
  logic [PTR_W-1:0] prev_q, prev_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic accept;
  logic load;
  logic drain;
  logic nonmono;

  // The first pointer of a matrix produces no output, so it never waits on the output reg.
  assign s_ptr_tready = (state_q == StFirst) | ~tvalid_q | m_len_tready;

  assign accept  = s_ptr_tvalid & s_ptr_tready;
  assign load    = accept & (state_q == StRun);
  assign drain   = tvalid_q & m_len_tready;
  assign nonmono = s_ptr_tdata < prev_q;

  always_comb begin
    state_d   = state_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    idx_d     = idx_q;
    prev_d    = prev_q;
    row_cnt_d = row_cnt_q;
    err_d     = err_q;
    done_d    = accept & s_ptr_tlast;

    if (drain) begin
      tvalid_d = 1'b0;
    end

    if (accept) begin
      prev_d = s_ptr_tdata;
      unique case (state_q)
        StFirst: begin
          row_cnt_d = '0;
          if (!s_ptr_tlast) begin
            state_d = StRun;
          end
        end
        StRun: begin
          tvalid_d  = 1'b1;
          tdata_d   = nonmono ? '0 : s_ptr_tdata - prev_q;
          tlast_d   = s_ptr_tlast;
          idx_d     = row_cnt_q;
          row_cnt_d = row_cnt_q + ROW_W'(1);
          err_d     = err_q | nonmono;
          if (s_ptr_tlast) begin
            state_d = StFirst;
          end
        end
        default: state_d = StFirst;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StFirst;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tlast_q   <= 1'b0;
      idx_q     <= '0;
      prev_q    <= '0;
      row_cnt_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      tlast_q   <= tlast_d;
      idx_q     <= idx_d;
      prev_q    <= prev_d;
      row_cnt_q <= row_cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign m_len_tvalid = tvalid_q;
  assign m_len_tdata  = tdata_q;
  assign m_len_tlast  = tlast_q;
  assign m_row_idx    = idx_q;
  assign done         = done_q;
  assign err_nonmono  = err_q;

endmodule

// File: tb/tb_rowptr_len_gen.sv
// Directed bench for rowptr_len_gen: inputs change 1ns after posedge, outputs sampled on negedge.
module tb_rowptr_len_gen;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s_ptr_tvalid = 1'b0;
  logic [31:0] s_ptr_tdata = '0;
  logic        s_ptr_tlast = 1'b0;
  logic        s_ptr_tready;
  logic        m_len_tvalid;
  logic [31:0] m_len_tdata;
  logic        m_len_tlast;
  logic        m_len_tready = 1'b1;
  logic [31:0] m_row_idx;
  logic        done;
  logic        err_nonmono;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [31:0] q_len[$];
  logic [31:0] q_idx[$];
  logic        q_last[$];

  rowptr_len_gen #(.PTR_W(32), .ROW_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .s_ptr_tvalid(s_ptr_tvalid), .s_ptr_tdata(s_ptr_tdata), .s_ptr_tlast(s_ptr_tlast),
    .s_ptr_tready(s_ptr_tready),
    .m_len_tvalid(m_len_tvalid), .m_len_tdata(m_len_tdata), .m_len_tlast(m_len_tlast),
    .m_len_tready(m_len_tready), .m_row_idx(m_row_idx),
    .done(done), .err_nonmono(err_nonmono)
  );

  always #5 clk = ~clk;

  // Record every output beat that completes at the following posedge.
  always @(negedge clk) begin
    if (rstn && m_len_tvalid && m_len_tready) begin
      q_len.push_back(m_len_tdata);
      q_idx.push_back(m_row_idx);
      q_last.push_back(m_len_tlast);
    end
    if (rstn && done) done_cnt++;
  end

  task automatic clear_log();
    q_len.delete();
    q_idx.delete();
    q_last.delete();
    done_cnt = 0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    bit ok = 0;
    s_ptr_tvalid = 1'b1;
    s_ptr_tdata  = d;
    s_ptr_tlast  = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_ptr_tready) begin
        @(posedge clk);
        #1;
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake timeout ptr=%0d", d);
    end
  endtask

  task automatic idle(input int n);
    s_ptr_tvalid = 1'b0;
    s_ptr_tlast  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_beats(input int n, input logic [31:0] el[4], input logic [31:0] ei[4],
                             input logic et[4], input int edone, input string name);
    checks++;
    if (q_len.size() !== n) begin
      errors++;
      $display("FAIL %s beat count got %0d exp %0d", name, q_len.size(), n);
    end
    for (int i = 0; i < n && i < q_len.size(); i++) begin
      checks++;
      if (q_len[i] !== el[i] || q_idx[i] !== ei[i] || q_last[i] !== et[i]) begin
        errors++;
        $display("FAIL %s beat%0d got len=%0d idx=%0d last=%0d exp len=%0d idx=%0d last=%0d",
                 name, i, q_len[i], q_idx[i], q_last[i], el[i], ei[i], et[i]);
      end
    end
    checks++;
    if (done_cnt !== edone) begin
      errors++;
      $display("FAIL %s done pulses got %0d exp %0d", name, done_cnt, edone);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #12;
    checks++;
    if ({m_len_tvalid, m_len_tdata, m_len_tlast, m_row_idx, done, err_nonmono} !== '0) begin
      errors++;
      $display("FAIL reset outputs got v=%0b d=%0d l=%0b i=%0d done=%0b err=%0b exp all 0",
               m_len_tvalid, m_len_tdata, m_len_tlast, m_row_idx, done, err_nonmono);
    end
    checks++;
    if (s_ptr_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset s_ptr_tready got %0b exp 1", s_ptr_tready);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(1);
  endtask

  task automatic test_basic();
    clear_log();
    m_len_tready = 1'b1;
    send_beat(0, 0); send_beat(3, 0); send_beat(3, 0); send_beat(7, 1);
    idle(3);
    check_beats(3, '{3, 0, 4, 0}, '{0, 1, 2, 0}, '{0, 0, 1, 0}, 1, "t1_basic");
    checks++;
    if (err_nonmono !== 1'b0) begin
      errors++;
      $display("FAIL t1 err_nonmono got %0b exp 0", err_nonmono);
    end
  endtask

  task automatic test_backpressure();
    clear_log();
    m_len_tready = 1'b0;
    send_beat(0, 0);
    send_beat(3, 0);
    s_ptr_tvalid = 1'b1;
    s_ptr_tdata  = 3;
    s_ptr_tlast  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (m_len_tvalid !== 1'b1 || m_len_tdata !== 3 || m_row_idx !== 0 || s_ptr_tready !== 1'b0)
      begin
        errors++;
        $display("FAIL t2 hold cyc%0d got v=%0b len=%0d idx=%0d rdy=%0b exp v=1 len=3 idx=0 rdy=0",
                 c, m_len_tvalid, m_len_tdata, m_row_idx, s_ptr_tready);
      end
      @(posedge clk);
      #1;
    end
    m_len_tready = 1'b1;
    send_beat(3, 0); send_beat(7, 1);
    idle(3);
    check_beats(3, '{3, 0, 4, 0}, '{0, 1, 2, 0}, '{0, 0, 1, 0}, 1, "t2_backpressure");
  endtask

  task automatic test_zero_row();
    clear_log();
    send_beat(5, 1);
    idle(3);
    check_beats(0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 1, "t3_zero_row");
    clear_log();
    send_beat(0, 0); send_beat(2, 1);
    idle(3);
    check_beats(1, '{2, 0, 0, 0}, '{0, 0, 0, 0}, '{1, 0, 0, 0}, 1, "t3_next");
  endtask

  task automatic test_nonmono();
    clear_log();
    send_beat(8, 0);
    send_beat(4, 0);
    checks++;
    if (err_nonmono !== 1'b1) begin
      errors++;
      $display("FAIL t4 err after 4 got %0b exp 1", err_nonmono);
    end
    send_beat(6, 1);
    idle(3);
    check_beats(2, '{0, 2, 0, 0}, '{0, 1, 0, 0}, '{0, 1, 0, 0}, 1, "t4_nonmono");
  endtask

  task automatic test_back_to_back();
    clear_log();
    send_beat(0, 0); send_beat(1, 0); send_beat(4, 1); send_beat(0, 0); send_beat(2, 1);
    idle(3);
    check_beats(3, '{1, 3, 2, 0}, '{0, 1, 0, 0}, '{0, 1, 1, 0}, 2, "t5_back_to_back");
    checks++;
    if (err_nonmono !== 1'b1) begin
      errors++;
      $display("FAIL t5 sticky err got %0b exp 1", err_nonmono);
    end
  endtask

  task automatic test_reset_mid();
    m_len_tready = 1'b0;
    send_beat(0, 0);
    send_beat(5, 0);
    s_ptr_tvalid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (m_len_tvalid !== 1'b0 || err_nonmono !== 1'b0) begin
      errors++;
      $display("FAIL t6 async reset got v=%0b err=%0b exp v=0 err=0", m_len_tvalid, err_nonmono);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    m_len_tready = 1'b1;
    clear_log();
    send_beat(10, 0); send_beat(12, 1);
    idle(3);
    check_beats(1, '{2, 0, 0, 0}, '{0, 0, 0, 0}, '{1, 0, 0, 0}, 1, "t6_reset_mid");
    checks++;
    if (err_nonmono !== 1'b0) begin
      errors++;
      $display("FAIL t6 err after reset got %0b exp 0", err_nonmono);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_row();
    test_nonmono();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
